// File: rtl/pim_pkg.sv
// Shared PIM definitions: activation frame geometry and loader FSM encoding.
package pim_pkg;

  localparam int ACT_WORDS  = 9;   // 32-bit words per activation frame (288 bits)
  localparam int ACT_WORD_W = 32;  // activation word width
  localparam int ACT_CNT_W  = 8;   // width of the buffer slot index bus
  localparam int ACT_IDX_W  = 4;   // internal word index width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIRE = 2'd2,
    ST_DONE = 2'd3
  } act_state_e;

  // True when idx addresses the final word of an n-word frame.
  function automatic logic idx_is_last(input logic [ACT_IDX_W-1:0] idx,
                                       input int unsigned          n);
    return ({28'd0, idx} == (n - 32'd1));
  endfunction

endpackage

// File: rtl/activation_loader.sv
// Activation loader: streams NUM_WORDS upstream words into the activation
// buffer, then fires one frame-complete pulse once the PIM macro is free.
module activation_loader
  import pim_pkg::*;
#(
  parameter int NUM_WORDS = ACT_WORDS,
  parameter int WORD_W    = ACT_WORD_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_wvalid,
  input  logic [WORD_W-1:0]    i_wdata,
  output logic                 o_wready,
  input  logic                 i_pim_busy,
  output logic                 o_activation_in_en,
  output logic [ACT_CNT_W-1:0] o_counter,
  output logic [WORD_W-1:0]    o_data,
  output logic                 o_activation_out_en,
  output logic                 o_busy,
  output logic                 o_done
);

  act_state_e           state_r;
  act_state_e           state_nxt_s;
  logic [ACT_IDX_W-1:0] idx_r;
  logic                 accept_s;
  logic                 last_s;
  logic                 in_en_nxt_s;
  logic                 out_en_nxt_s;
  logic                 done_nxt_s;

  // Ready and busy are pure functions of state so upstream sees them early.
  assign o_wready = (state_r == ST_LOAD);
  assign o_busy   = (state_r != ST_IDLE);

  // An abort in the same cycle as a word kills that word.
  assign accept_s = i_wvalid & o_wready & ~i_abort;
  assign last_s   = idx_is_last(idx_r, NUM_WORDS);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort wins over everything, including start.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_abort)      state_nxt_s = ST_IDLE;
        else if (i_start) state_nxt_s = ST_LOAD;
        else              state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (i_abort)                state_nxt_s = ST_IDLE;
        else if (accept_s && last_s) state_nxt_s = ST_FIRE;
        else                        state_nxt_s = ST_LOAD;
      end
      ST_FIRE: begin
        if (i_abort)          state_nxt_s = ST_IDLE;
        else if (!i_pim_busy) state_nxt_s = ST_DONE;
        else                  state_nxt_s = ST_FIRE;
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Pulse decode for the registered strobes; abort suppresses every pulse.
  always_comb begin
    in_en_nxt_s  = 1'b0;
    out_en_nxt_s = 1'b0;
    done_nxt_s   = 1'b0;
    case (state_r)
      ST_LOAD: in_en_nxt_s  = accept_s;
      ST_FIRE: out_en_nxt_s = ~i_pim_busy & ~i_abort;
      ST_DONE: done_nxt_s   = ~i_abort;
      default: begin
        in_en_nxt_s  = 1'b0;
        out_en_nxt_s = 1'b0;
        done_nxt_s   = 1'b0;
      end
    endcase
  end

  // Registered strobes to the buffer and the done pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_activation_in_en  <= 1'b0;
      o_activation_out_en <= 1'b0;
      o_done              <= 1'b0;
    end else begin
      o_activation_in_en  <= in_en_nxt_s;
      o_activation_out_en <= out_en_nxt_s;
      o_done              <= done_nxt_s;
    end
  end

  // Word index: cleared on start or abort, advances per word, parks on the last slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx_r <= 4'd0;
    end else if (i_abort) begin
      idx_r <= 4'd0;
    end else if ((state_r == ST_IDLE) && i_start) begin
      idx_r <= 4'd0;
    end else if (accept_s && !last_s) begin
      idx_r <= idx_r + 4'd1;
    end else begin
      idx_r <= idx_r;
    end
  end

  // Data and slot index only change with an accepted word, so they hold otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data    <= '0;
      o_counter <= 8'd0;
    end else if (accept_s) begin
      o_data    <= i_wdata;
      o_counter <= {{(ACT_CNT_W-ACT_IDX_W){1'b0}}, idx_r};
    end else begin
      o_data    <= o_data;
      o_counter <= o_counter;
    end
  end

endmodule

// File: tb/tb_activation_loader.sv
// Self-checking bench for activation_loader: directed scenarios plus random
// traffic, all compared every cycle against a frame-level behavioural model.
module tb_activation_loader;
  import pim_pkg::*;

  localparam int N = 9;
  localparam int W = 32;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_start = 1'b0;
  logic         i_abort = 1'b0;
  logic         i_wvalid = 1'b0;
  logic [W-1:0] i_wdata = '0;
  logic         i_pim_busy = 1'b0;
  logic         o_wready;
  logic         o_activation_in_en;
  logic [7:0]   o_counter;
  logic [W-1:0] o_data;
  logic         o_activation_out_en;
  logic         o_busy;
  logic         o_done;

  always #5 i_clk = ~i_clk;

  activation_loader #(.NUM_WORDS(N), .WORD_W(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_wvalid(i_wvalid), .i_wdata(i_wdata), .o_wready(o_wready),
    .i_pim_busy(i_pim_busy), .o_activation_in_en(o_activation_in_en),
    .o_counter(o_counter), .o_data(o_data),
    .o_activation_out_en(o_activation_out_en), .o_busy(o_busy), .o_done(o_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is "collecting" until N words are taken,
  // then "awaiting" a free macro, then "finishing" for one cycle.
  bit           m_collect, m_await, m_finish;
  int           m_taken;
  logic         e_in_en, e_out_en, e_done;
  logic [7:0]   e_cnt;
  logic [W-1:0] e_data;

  task automatic model_reset();
    m_collect = 0; m_await = 0; m_finish = 0; m_taken = 0;
    e_in_en = 0; e_out_en = 0; e_done = 0; e_cnt = 8'd0; e_data = '0;
  endtask

  task automatic model_next(input logic a, input logic s, input logic v,
                            input logic [W-1:0] d, input logic b);
    e_in_en = 0; e_out_en = 0; e_done = 0;
    if (a) begin
      m_collect = 0; m_await = 0; m_finish = 0; m_taken = 0;
    end else if (m_finish) begin
      m_finish = 0; e_done = 1;
    end else if (m_await) begin
      if (!b) begin m_await = 0; m_finish = 1; e_out_en = 1; end
    end else if (m_collect) begin
      if (v) begin
        e_in_en = 1; e_cnt = 8'(m_taken); e_data = d;
        m_taken++;
        if (m_taken == N) begin m_collect = 0; m_await = 1; end
      end
    end else if (s) begin
      m_collect = 1; m_taken = 0;
    end
  endtask

  // Observation statistics gathered by the compare process.
  int           cyc, in_cnt, out_cnt, done_cnt, last_in, out_cyc, done_cyc;
  logic [7:0]   first_cnt, last_cnt;
  logic [W-1:0] first_data, last_data;

  task automatic clear_stats();
    in_cnt = 0; out_cnt = 0; done_cnt = 0; last_in = -1; out_cyc = -1; done_cyc = -1;
    first_cnt = 8'hFF; last_cnt = 8'hFF; first_data = '0; last_data = '0;
  endtask

  // Compare process: every cycle out of reset, all outputs against the model.
  initial begin
    cyc = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        cyc++;
        chk("in_en",  64'(o_activation_in_en),  64'(e_in_en));
        chk("out_en", 64'(o_activation_out_en), 64'(e_out_en));
        chk("done",   64'(o_done),              64'(e_done));
        chk("wready", 64'(o_wready),            64'(m_collect));
        chk("busy",   64'(o_busy),              64'(m_collect | m_await | m_finish));
        chk("counter", 64'(o_counter),          64'(e_cnt));
        chk("data",   64'(o_data),              64'(e_data));
        if (o_activation_in_en) begin
          in_cnt++;
          last_in = cyc;
          if (in_cnt == 1) begin first_cnt = o_counter; first_data = o_data; end
          last_cnt = o_counter; last_data = o_data;
        end
        if (o_activation_out_en) begin out_cnt++; out_cyc = cyc; end
        if (o_done) begin done_cnt++; done_cyc = cyc; end
      end
    end
  end

  task automatic step(input logic a, input logic s, input logic v,
                      input logic [W-1:0] d, input logic b);
    i_abort = a; i_start = s; i_wvalid = v; i_wdata = d; i_pim_busy = b;
    @(posedge i_clk);
    model_next(a, s, v, d, b);
    @(negedge i_clk);
  endtask

  task automatic idle(input int n, input logic b);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, '0, b);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clear_stats();
    repeat (3) @(negedge i_clk);
    chk("rst_in_en", 64'(o_activation_in_en), 64'd0);
    chk("rst_out_en", 64'(o_activation_out_en), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_wready", 64'(o_wready), 64'd0);
    chk("rst_counter", 64'(o_counter), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    i_rst = 1'b0;

    // Nominal frame: 9 back-to-back words 0xA0..0xA8.
    clear_stats();
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, 1'b1, 32'hA0 + 32'(i), 1'b0);
    idle(4, 1'b0);
    chk("nom_in_cnt", 64'(in_cnt), 64'd9);
    chk("nom_first", 64'({first_cnt, first_data}), {32'd0, 8'd0, 32'hA0} >> 0);
    chk("nom_last_cnt", 64'(last_cnt), 64'd8);
    chk("nom_last_data", 64'(last_data), 64'hA8);
    chk("nom_out_cnt", 64'(out_cnt), 64'd1);
    chk("nom_out_gap", 64'(out_cyc - last_in), 64'd1);
    chk("nom_done_gap", 64'(done_cyc - out_cyc), 64'd1);
    chk("nom_done_cnt", 64'(done_cnt), 64'd1);

    // Stalled source: wvalid toggles every cycle.
    clear_stats();
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 2 * N; k++)
      step(1'b0, 1'b0, (k % 2) == 0, 32'hB0 + 32'(k / 2), 1'b0);
    idle(4, 1'b0);
    chk("stall_in_cnt", 64'(in_cnt), 64'd9);
    chk("stall_last_cnt", 64'(last_cnt), 64'd8);
    chk("stall_out_cnt", 64'(out_cnt), 64'd1);
    chk("stall_out_after", 64'(out_cyc > last_in), 64'd1);

    // Backpressure: macro busy for 5 cycles after entering FIRE.
    clear_stats();
    step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, 1'b1, 32'hC0 + 32'(i), 1'b1);
    idle(5, 1'b1);
    idle(4, 1'b0);
    chk("bp_out_cnt", 64'(out_cnt), 64'd1);
    chk("bp_out_gap", 64'(out_cyc - last_in), 64'd6);

    // Abort after 4 words, then a fresh frame restarts at slot 0.
    clear_stats();
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 32'hD0 + 32'(i), 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hDD, 1'b0);
    chk("abort_busy", 64'(o_busy), 64'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 32'hEE, 1'b0);
    chk("abort_in_cnt", 64'(in_cnt), 64'd4);
    chk("abort_out_cnt", 64'(out_cnt), 64'd0);
    clear_stats();
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, 1'b1, 32'hE0 + 32'(i), 1'b0);
    idle(3, 1'b0);
    chk("restart_first_cnt", 64'(first_cnt), 64'd0);
    chk("restart_in_cnt", 64'(in_cnt), 64'd9);
    chk("restart_out_cnt", 64'(out_cnt), 64'd1);

    // Start and abort together in IDLE: stays idle.
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("sa_busy", 64'(o_busy), 64'd0);
    step(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
    chk("sa_busy2", 64'(o_busy), 64'd0);

    // Asynchronous reset between edges in the middle of a load.
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'hF0 + 32'(i), 1'b0);
    i_wvalid = 1'b1; i_wdata = 32'hF3;
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_in_en", 64'(o_activation_in_en), 64'd0);
    chk("arst_out_en", 64'(o_activation_out_en), 64'd0);
    chk("arst_done", 64'(o_done), 64'd0);
    chk("arst_busy", 64'(o_busy), 64'd0);
    chk("arst_wready", 64'(o_wready), 64'd0);
    chk("arst_counter", 64'(o_counter), 64'd0);
    chk("arst_data", 64'(o_data), 64'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    model_reset();
    i_rst = 1'b0;
    clear_stats();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'hF8, 1'b0);
    chk("arst_no_resume", 64'(in_cnt), 64'd0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++)
      step(($urandom % 40) == 0, ($urandom % 4) == 0, $urandom % 2,
           $urandom, ($urandom % 3) == 0);
    idle(20, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/activation_loader.md
ACTIVATION_LOADER -- requirements
Module: activation_loader

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 9, meaning the number of 32-bit words per activation frame (9 x 32 = 288 bits).
REQ-002 SHALL have parameter WORD_W, default 32, meaning the data word width.
REQ-003 SHALL have port i_clk  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_start  input  1  begins a frame load; honoured only in IDLE.
REQ-006 SHALL have port i_abort  input  1  cancels the frame in any state.
REQ-007 SHALL have port i_wvalid  input  1  upstream word valid.
REQ-008 SHALL have port i_wdata  input  WORD_W  upstream activation word.
REQ-009 SHALL have port o_wready  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port i_pim_busy  input  1  downstream PIM macro busy; blocks the fire pulse.
REQ-011 SHALL have port o_activation_in_en  output  1  buffer write strobe.
REQ-012 SHALL have port o_counter  output  8  buffer word slot index.
REQ-013 SHALL have port o_data  output  WORD_W  word to the buffer.
REQ-014 SHALL have port o_activation_out_en  output  1  one-cycle frame-complete pulse to the buffer.
REQ-015 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port o_done  output  1  one-cycle pulse after the fire pulse.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD, FIRE and DONE.
REQ-018 SHALL move from IDLE to LOAD on i_start and clear the word index to 0.
REQ-019 SHALL drive o_wready=1 only in LOAD, combinationally from state.
REQ-020 SHALL, on each accepted word (i_wvalid & o_wready), register o_data=i_wdata, o_counter=index and o_activation_in_en=1 for exactly one cycle (1-cycle latency), then increment the index.
REQ-021 SHALL move from LOAD to FIRE on acceptance of the word at index NUM_WORDS-1; index saturates and does not wrap.
REQ-022 SHALL, in FIRE, register o_activation_out_en=1 for exactly one cycle on the first cycle with i_pim_busy=0, then go to DONE; the fire pulse follows the last in_en by at least one cycle.
REQ-023 SHALL, in DONE, pulse o_done for one cycle and return to IDLE.
REQ-024 SHALL hold o_counter and o_data stable when o_activation_in_en=0.
REQ-025 SHALL ignore i_start outside IDLE, and gaps in i_wvalid in LOAD (wait indefinitely).
REQ-026 SHALL, on i_abort, return to IDLE next cycle, clear the index, suppress any pending in_en/out_en/done pulse, and never emit a fire pulse for the aborted frame.
REQ-027 SHALL give i_abort priority when i_abort and i_start are asserted together in IDLE (stay in IDLE).
REQ-028 SHALL treat i_pim_busy as don't-care outside FIRE.

Reset
REQ-029 SHALL, on i_rst asserted (asynchronous), force state IDLE, index 0, o_data 0, o_counter 0, and o_activation_in_en, o_activation_out_en and o_done 0; o_wready and o_busy then evaluate to 0.
REQ-030 SHALL, on reset asserted mid-frame, discard the frame and require a new i_start after release.

Structure
REQ-031 SHALL take ACT_WORDS=9, ACT_WORD_W=32, ACT_CNT_W=8 and the FSM state encoding from the shared package pim_pkg.
REQ-032 SHALL be a single flat module with no sub-module; the index is 4 bits, zero-extended onto o_counter.

Verification
REQ-033 SHALL verify the nominal frame: start, then 9 back-to-back words 0xA0..0xA8 with pim_busy=0 -> in_en at counter 0..8 carrying 0xA0..0xA8, a single out_en one cycle after the last in_en, then done.
REQ-034 SHALL verify a stalled source: i_wvalid toggled 1/0 every cycle -> 9 in_en pulses total, counters contiguous 0..8, no out_en before the ninth.
REQ-035 SHALL verify backpressure: pim_busy=1 for 5 cycles on entering FIRE -> out_en delayed exactly until the cycle after busy drops, one pulse only.
REQ-036 SHALL verify abort: abort after 4 words -> IDLE, no out_en; a new frame restarts at counter 0.
REQ-037 SHALL verify simultaneous start and abort in IDLE -> stays IDLE, o_busy=0.
REQ-038 SHALL verify async reset asserted between clock edges mid-LOAD -> all outputs 0 immediately, state IDLE.
